// File: rtl/decoder_x4_seq.sv
// Registered 2-to-4 decoder with per-line pulse stretch, sticky pending and
// overflow flags cleared by per-line acknowledge, and a registered irq.
module decoder_x4_seq #(
  parameter int HOLD = 1,
  parameter int CW   = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] z,
  input  logic       y,
  input  logic [3:0] ack,
  output logic [3:0] x,
  output logic [3:0] pend,
  output logic [3:0] ovf,
  output logic       irq
);

  localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD);
  localparam logic [CW-1:0] ONE      = CW'(1);

  logic [CW-1:0] cnt [4];
  logic [3:0]    hit;
  logic [3:0]    pend_nxt;
  logic [3:0]    ovf_nxt;

  always_comb begin
    hit = 4'b0000;
    if (y) hit[z] = 1'b1;
  end

  // A hit in the same cycle as its ack wins, so the new event stays pending
  // while the previous overflow is acknowledged away.
  always_comb begin
    pend_nxt = hit | (pend & ~ack);
    ovf_nxt  = (hit & pend & ~ack) | (ovf & ~ack);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
      pend <= 4'b0000;
      ovf  <= 4'b0000;
      irq  <= 1'b0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (hit[i])
          cnt[i] <= HOLD_VAL;
        else if (cnt[i] != '0)
          cnt[i] <= cnt[i] - ONE;
      end
      pend <= pend_nxt;
      ovf  <= ovf_nxt;
      irq  <= |pend_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) x[i] = (cnt[i] != '0);
  end

endmodule

// File: tb/tb_decoder_x4_seq.sv
// Directed bench for decoder_x4_seq: four instances (HOLD 1/3/4/8) share stimulus,
// each test checks the instance whose HOLD it targets.
module tb_decoder_x4_seq;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [1:0] z;
  logic       y;
  logic [3:0] ack;

  logic [3:0] x1, pend1, ovf1;  logic irq1;
  logic [3:0] x3, pend3, ovf3;  logic irq3;
  logic [3:0] x4, pend4, ovf4;  logic irq4;
  logic [3:0] x8, pend8, ovf8;  logic irq8;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  decoder_x4_seq #(.HOLD(1), .CW(8)) d1 (.clk(clk), .reset_n(reset_n), .z(z), .y(y), .ack(ack),
                                         .x(x1), .pend(pend1), .ovf(ovf1), .irq(irq1));
  decoder_x4_seq #(.HOLD(3), .CW(8)) d3 (.clk(clk), .reset_n(reset_n), .z(z), .y(y), .ack(ack),
                                         .x(x3), .pend(pend3), .ovf(ovf3), .irq(irq3));
  decoder_x4_seq #(.HOLD(4), .CW(8)) d4 (.clk(clk), .reset_n(reset_n), .z(z), .y(y), .ack(ack),
                                         .x(x4), .pend(pend4), .ovf(ovf4), .irq(irq4));
  decoder_x4_seq #(.HOLD(8), .CW(8)) d8 (.clk(clk), .reset_n(reset_n), .z(z), .y(y), .ack(ack),
                                         .x(x8), .pend(pend8), .ovf(ovf8), .irq(irq8));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Advance to just after the next rising edge; inputs change here, outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    y = 1'b0; z = 2'd0; ack = 4'b0000;
    reset_n = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
  endtask

  logic [3:0] exp_ovl [5] = '{4'b1000, 4'b1001, 4'b1001, 4'b0001, 4'b0000};

  initial begin
    // reset with active request on the inputs
    reset_n = 1'b0; y = 1'b1; z = 2'd2; ack = 4'b0000;
    tick(); tick(); tick();
    chk("rst_x",    {28'd0, x1},    32'h0);
    chk("rst_pend", {28'd0, pend1}, 32'h0);
    chk("rst_ovf",  {28'd0, ovf1},  32'h0);
    chk("rst_irq",  {31'd0, irq1},  32'h0);
    reset_n = 1'b1; y = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("idle", {15'd0, x1, pend1, ovf1, irq1, x8, pend8}, 32'h0);
    end

    // HOLD=1 decode sweep
    do_reset();
    y = 1'b1;
    for (int i = 0; i < 4; i++) begin
      z = 2'(i);
      tick();
      chk("sweep_x", {28'd0, x1}, 32'(4'b0001 << i));
    end
    y = 1'b0;
    tick();
    chk("sweep_off", {28'd0, x1},    32'h0);
    chk("sweep_pnd", {28'd0, pend1}, 32'hf);
    chk("sweep_irq", {31'd0, irq1},  32'h1);
    chk("sweep_ovf", {28'd0, ovf1},  32'h0);

    // HOLD=4 single hit on line 1: high cycles 1..4
    do_reset();
    z = 2'd1;
    for (int c = 0; c < 6; c++) begin
      y = (c == 0);
      tick();
      chk("hold4", {28'd0, x4}, (c + 1 <= 4) ? 32'h2 : 32'h0);
    end

    // HOLD=4 retrigger at cycle 2: high cycles 1..6
    do_reset();
    z = 2'd1;
    for (int c = 0; c < 8; c++) begin
      y = (c == 0 || c == 2);
      tick();
      chk("retrig", {28'd0, x4}, (c + 1 <= 6) ? 32'h2 : 32'h0);
    end

    // HOLD=3 overlapping stretches on lines 3 and 0
    do_reset();
    for (int c = 0; c < 5; c++) begin
      y = (c < 2);
      z = (c == 0) ? 2'd3 : 2'd0;
      tick();
      chk("overlap", {28'd0, x3}, {28'd0, exp_ovl[c]});
    end

    // pending / overflow / ack
    do_reset();
    y = 1'b1; z = 2'd2;
    tick();
    chk("p1_pend", {28'd0, pend1}, 32'h4);
    chk("p1_irq",  {31'd0, irq1},  32'h1);
    chk("p1_ovf",  {28'd0, ovf1},  32'h0);
    tick();
    chk("p2_ovf",  {28'd0, ovf1},  32'h4);
    chk("p2_pend", {28'd0, pend1}, 32'h4);
    y = 1'b0; ack = 4'b0100;
    tick();
    chk("p3_pend", {28'd0, pend1}, 32'h0);
    chk("p3_ovf",  {28'd0, ovf1},  32'h0);
    chk("p3_irq",  {31'd0, irq1},  32'h0);
    y = 1'b1;
    tick();
    chk("p4_pend", {28'd0, pend1}, 32'h4);
    chk("p4_ovf",  {28'd0, ovf1},  32'h0);
    tick();
    chk("p5_pend", {28'd0, pend1}, 32'h4);
    chk("p5_ovf",  {28'd0, ovf1},  32'h0);
    chk("p5_irq",  {31'd0, irq1},  32'h1);
    y = 1'b0; ack = 4'b0001;
    tick();
    chk("p6_noack", {28'd0, pend1}, 32'h4);
    ack = 4'b0000;

    // HOLD=8 async reset mid-stretch
    do_reset();
    y = 1'b1; z = 2'd1;
    tick();
    y = 1'b0;
    tick(); tick();
    chk("ar_pre", {28'd0, x8}, 32'h2);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_x",    {28'd0, x8},    32'h0);
    chk("ar_pend", {28'd0, pend8}, 32'h0);
    chk("ar_irq",  {31'd0, irq8},  32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("ar_post", {28'd0, x8}, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
